// File: rtl/clos_cfg_alloc.sv
// clos_cfg_alloc
//   Path allocator and configuration controller for the 5-port data Clos
//   switch (5 input modules, MN centre modules, no output modules).
//   A route request on input dir d / VC k (slot s = d*NN+k) is bound to the
//   lowest centre module m whose IM link d->m and whose output toward the
//   requested direction are both free. m is the output VC. The path stays
//   configured until released.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req[d][k]         route request, held until gnt/nack
//   req_dst[d][k]     requested output dir (0=S 1=W 2=N 3=E 4=L)
//   rel[d][k]         release pulse, tears down that slot's path
//   gnt / nack        one-cycle grant / reject (illegal turn) pulse per slot
//   gnt_cm            one-hot CM of the current grant, else 0
//   imcfg[d][m][k]    IM d connects input VC k to CM m
//   s/n/w/e/lcfg[m]   CM m output select, one-hot over its legal inputs
//   busy              allocator FSM not idle
module clos_cfg_alloc #(
  parameter int MN = 2,
  parameter int NN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0][NN-1:0]            req,
  input  logic [4:0][NN-1:0][2:0]       req_dst,
  input  logic [4:0][NN-1:0]            rel,
  output logic [4:0][NN-1:0]            gnt,
  output logic [4:0][NN-1:0]            nack,
  output logic [MN-1:0]                 gnt_cm,
  output logic [4:0][MN-1:0][NN-1:0]    imcfg,
  output logic [MN-1:0][1:0]            scfg,
  output logic [MN-1:0][1:0]            ncfg,
  output logic [MN-1:0][3:0]            wcfg,
  output logic [MN-1:0][3:0]            ecfg,
  output logic [MN-1:0][3:0]            lcfg,
  output logic                          busy
);
  localparam int unsigned NS = 5 * NN;
  localparam int unsigned SW = $clog2(NS);
  localparam int unsigned CW = (MN > 1) ? $clog2(MN) : 1;

  typedef enum logic [2:0] {IDLE, ARB, SEARCH, COMMIT, NACK} state_e;

  state_e        state_q;
  logic [SW-1:0] rr_q;
  logic [SW-1:0] slot_q;
  logic [2:0]    dir_q;
  logic [2:0]    dst_q;
  logic [CW-1:0] cm_sel_q;
  logic [NS-1:0] valid_q;
  logic [CW-1:0] tab_cm_q  [NS];
  logic [2:0]    tab_dst_q [NS];
  logic [NS-1:0] gnt_q;
  logic [NS-1:0] nack_q;
  logic [MN-1:0] gnt_cm_q;

  logic [NS-1:0]      req_f;
  logic [NS-1:0]      rel_f;
  logic [NS-1:0][2:0] dst_f;
  logic [NS-1:0]      cand;
  logic [SW-1:0]      next_rr;

  assign req_f   = req;
  assign rel_f   = rel;
  assign dst_f   = req_dst;
  assign cand    = req_f & ~valid_q;
  assign next_rr = (slot_q == SW'(NS - 1)) ? '0 : slot_q + 1'b1;

  // {legal, bit position} of input dir d inside the cfg vector of output o
  function automatic logic [2:0] turn_bit(input logic [2:0] o, input logic [2:0] d);
    logic [2:0] r;
    r = '0;
    case (o)
      3'd0: begin
        case (d) 3'd2: r = 3'b100; 3'd4: r = 3'b101; default: r = '0; endcase
      end
      3'd1: begin
        case (d) 3'd0: r = 3'b100; 3'd2: r = 3'b101; 3'd3: r = 3'b110; 3'd4: r = 3'b111; default: r = '0; endcase
      end
      3'd2: begin
        case (d) 3'd0: r = 3'b100; 3'd4: r = 3'b101; default: r = '0; endcase
      end
      3'd3: begin
        case (d) 3'd0: r = 3'b100; 3'd1: r = 3'b101; 3'd2: r = 3'b110; 3'd4: r = 3'b111; default: r = '0; endcase
      end
      3'd4: begin
        case (d) 3'd0: r = 3'b100; 3'd1: r = 3'b101; 3'd2: r = 3'b110; 3'd3: r = 3'b111; default: r = '0; endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic turn_legal(input logic [2:0] o, input logic [2:0] d);
    logic [2:0] r;
    r = turn_bit(o, d);
    return r[2];
  endfunction

  // Round-robin pick: first requesting, unallocated slot at/after rr_q
  logic          arb_found;
  logic [SW-1:0] arb_slot;
  logic [2:0]    arb_dir;
  always_comb begin
    int unsigned s;
    arb_found = 1'b0;
    arb_slot  = '0;
    arb_dir   = '0;
    s         = 0;
    for (int unsigned i = 0; i < NS; i++) begin
      s = (32'(rr_q) + i) % NS;
      if (!arb_found && cand[s]) begin
        arb_found = 1'b1;
        arb_slot  = SW'(s);
        arb_dir   = 3'(s / NN);
      end
    end
  end

  // Lowest CM with both the IM link and the target output unused
  logic          srch_found;
  logic [CW-1:0] srch_cm;
  always_comb begin
    logic [MN-1:0] link_busy;
    logic [MN-1:0] out_busy;
    link_busy  = '0;
    out_busy   = '0;
    srch_found = 1'b0;
    srch_cm    = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      if (valid_q[s]) begin
        if (3'(s / NN) == dir_q)    link_busy[tab_cm_q[s]] = 1'b1;
        if (tab_dst_q[s] == dst_q)  out_busy[tab_cm_q[s]]  = 1'b1;
      end
    end
    for (int unsigned m = 0; m < MN; m++) begin
      if (!srch_found && !link_busy[m] && !out_busy[m]) begin
        srch_found = 1'b1;
        srch_cm    = CW'(m);
      end
    end
  end

  // Switch configuration is a pure function of the allocation table
  always_comb begin
    logic [2:0] tbit;
    imcfg = '0;
    scfg  = '0;
    ncfg  = '0;
    wcfg  = '0;
    ecfg  = '0;
    lcfg  = '0;
    tbit  = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      tbit = turn_bit(tab_dst_q[s], 3'(s / NN));
      if (valid_q[s] && tbit[2]) begin
        imcfg[s / NN][tab_cm_q[s]][s % NN] = 1'b1;
        case (tab_dst_q[s])
          3'd0:    scfg[tab_cm_q[s]][tbit[0]]   = 1'b1;
          3'd1:    wcfg[tab_cm_q[s]][tbit[1:0]] = 1'b1;
          3'd2:    ncfg[tab_cm_q[s]][tbit[0]]   = 1'b1;
          3'd3:    ecfg[tab_cm_q[s]][tbit[1:0]] = 1'b1;
          3'd4:    lcfg[tab_cm_q[s]][tbit[1:0]] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      slot_q   <= '0;
      dir_q    <= '0;
      dst_q    <= '0;
      cm_sel_q <= '0;
      valid_q  <= '0;
      gnt_q    <= '0;
      nack_q   <= '0;
      gnt_cm_q <= '0;
      for (int unsigned s = 0; s < NS; s++) begin
        tab_cm_q[s]  <= '0;
        tab_dst_q[s] <= '0;
      end
    end else begin
      gnt_q    <= '0;
      nack_q   <= '0;
      gnt_cm_q <= '0;
      // Releases only hit allocated slots; the slot in COMMIT is never
      // allocated, so both updates can land on the same edge.
      for (int unsigned s = 0; s < NS; s++) begin
        if (rel_f[s] && valid_q[s]) valid_q[s] <= 1'b0;
      end
      case (state_q)
        IDLE: if (|cand) state_q <= ARB;
        ARB: begin
          if (arb_found) begin
            slot_q  <= arb_slot;
            dir_q   <= arb_dir;
            dst_q   <= dst_f[arb_slot];
            state_q <= SEARCH;
          end else begin
            state_q <= IDLE;
          end
        end
        SEARCH: begin
          if (!turn_legal(dst_q, dir_q)) begin
            state_q <= NACK;
          end else if (srch_found) begin
            cm_sel_q <= srch_cm;
            state_q  <= COMMIT;
          end else begin
            rr_q    <= next_rr;
            state_q <= IDLE;
          end
        end
        COMMIT: begin
          if (req_f[slot_q]) begin
            valid_q[slot_q]   <= 1'b1;
            tab_cm_q[slot_q]  <= cm_sel_q;
            tab_dst_q[slot_q] <= dst_q;
            gnt_q[slot_q]     <= 1'b1;
            gnt_cm_q[cm_sel_q] <= 1'b1;
          end
          rr_q    <= next_rr;
          state_q <= IDLE;
        end
        NACK: begin
          nack_q[slot_q] <= 1'b1;
          rr_q           <= next_rr;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign nack   = nack_q;
  assign gnt_cm = gnt_cm_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_clos_cfg_alloc.sv
module tb_clos_cfg_alloc;
  localparam int MN = 2;
  localparam int NN = 2;
  localparam int NS = 5 * NN;

  logic clk = 1'b0;
  logic rst;
  logic [NS-1:0]      req_v, rel_v, gnt_v, nack_v;
  logic [NS-1:0][2:0] dst_v;
  logic [MN-1:0]      gnt_cm;
  logic [4:0][MN-1:0][NN-1:0] imcfg;
  logic [MN-1:0][1:0] scfg, ncfg;
  logic [MN-1:0][3:0] wcfg, ecfg, lcfg;
  logic busy;

  always #5 clk = ~clk;

  clos_cfg_alloc #(.MN(MN), .NN(NN)) dut (
    .clk(clk), .rst(rst), .req(req_v), .req_dst(dst_v), .rel(rel_v),
    .gnt(gnt_v), .nack(nack_v), .gnt_cm(gnt_cm), .imcfg(imcfg),
    .scfg(scfg), .ncfg(ncfg), .wcfg(wcfg), .ecfg(ecfg), .lcfg(lcfg), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Legal inputs of each output dir (S,W,N,E,L), listed in cfg bit order
  int in_list [5][4] = '{'{2, 4, -1, -1}, '{0, 2, 3, 4}, '{0, 4, -1, -1},
                         '{0, 1, 2, 4},   '{0, 1, 2, 3}};

  function automatic int turn_pos(input int o, input int i);
    if (o < 0 || o > 4) return -1;
    for (int j = 0; j < 4; j++) if (in_list[o][j] == i) return j;
    return -1;
  endfunction

  // Reference model: allocation per slot plus the scan in progress.
  // phase counts cycles since a pending request was noticed:
  // 1 = choose slot, 2 = evaluate route, 3 = grant, 4 = reject, 0 = waiting.
  int m_alloc [NS];
  int m_dst   [NS];
  int rr = 0, phase = 0, cur = 0, cur_dst = 0, cur_cm = 0;
  int exp_gnt_slot = -1, exp_nack_slot = -1, exp_cm = -1;

  function automatic bit link_free(input int d, input int m);
    for (int s = 0; s < NS; s++) if (s / NN == d && m_alloc[s] == m) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit out_free(input int m, input int o);
    for (int s = 0; s < NS; s++) if (m_alloc[s] == m && m_dst[s] == o) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit [NS-1:0] freeing;
    bit pending;
    exp_gnt_slot  = -1;
    exp_nack_slot = -1;
    exp_cm        = -1;
    if (rst) begin
      for (int s = 0; s < NS; s++) m_alloc[s] = -1;
      rr = 0;
      phase = 0;
    end else begin
      freeing = '0;
      pending = 1'b0;
      for (int s = 0; s < NS; s++) begin
        if (rel_v[s] && m_alloc[s] >= 0) freeing[s] = 1'b1;
        if (req_v[s] && m_alloc[s] < 0) pending = 1'b1;
      end
      case (phase)
        0: if (pending) phase = 1;
        1: begin
          cur = -1;
          for (int i = 0; i < NS; i++)
            if (cur < 0 && req_v[(rr + i) % NS] && m_alloc[(rr + i) % NS] < 0) cur = (rr + i) % NS;
          if (cur < 0) phase = 0;
          else begin
            cur_dst = int'(dst_v[cur]);
            phase = 2;
          end
        end
        2: begin
          if (turn_pos(cur_dst, cur / NN) < 0) phase = 4;
          else begin
            cur_cm = -1;
            for (int m = 0; m < MN; m++)
              if (cur_cm < 0 && link_free(cur / NN, m) && out_free(m, cur_dst)) cur_cm = m;
            if (cur_cm < 0) begin
              rr = (cur + 1) % NS;
              phase = 0;
            end else phase = 3;
          end
        end
        3: begin
          if (req_v[cur]) begin
            m_alloc[cur] = cur_cm;
            m_dst[cur]   = cur_dst;
            exp_gnt_slot = cur;
            exp_cm       = cur_cm;
          end
          rr = (cur + 1) % NS;
          phase = 0;
        end
        default: begin
          exp_nack_slot = cur;
          rr = (cur + 1) % NS;
          phase = 0;
        end
      endcase
      for (int s = 0; s < NS; s++) if (freeing[s]) m_alloc[s] = -1;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    logic [NS-1:0] eg, en;
    logic [MN-1:0] ec;
    logic [4:0][MN-1:0][NN-1:0] ei;
    logic [MN-1:0][1:0] es, enn;
    logic [MN-1:0][3:0] ew, ee, el;
    int d, p, m;
    eg = '0; en = '0; ec = '0; ei = '0;
    es = '0; enn = '0; ew = '0; ee = '0; el = '0;
    if (exp_gnt_slot >= 0) begin
      eg[exp_gnt_slot] = 1'b1;
      ec[exp_cm] = 1'b1;
    end
    if (exp_nack_slot >= 0) en[exp_nack_slot] = 1'b1;
    for (int s = 0; s < NS; s++) begin
      if (m_alloc[s] >= 0) begin
        d = s / NN;
        m = m_alloc[s];
        p = turn_pos(m_dst[s], d);
        ei[d][m][s % NN] = 1'b1;
        case (m_dst[s])
          0: es[m][p] = 1'b1;
          1: ew[m][p] = 1'b1;
          2: enn[m][p] = 1'b1;
          3: ee[m][p] = 1'b1;
          default: el[m][p] = 1'b1;
        endcase
      end
    end
    check("gnt", gnt_v, eg);
    check("nack", nack_v, en);
    check("gnt_cm", gnt_cm, ec);
    check("busy", busy, phase != 0);
    check("imcfg", imcfg, ei);
    check("cm_cfg", {scfg, ncfg, wcfg, ecfg, lcfg}, {es, enn, ew, ee, el});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rel_v = '0;
    if (exp_gnt_slot >= 0)  req_v[exp_gnt_slot]  = 1'b0;
    if (exp_nack_slot >= 0) req_v[exp_nack_slot] = 1'b0;
  endtask

  task automatic request(input int s, input int dst);
    req_v[s] = 1'b1;
    dst_v[s] = 3'(dst);
  endtask

  task automatic wait_pulse(input int s, input bit want_nack, input int budget,
                            input string name, output int lat);
    lat = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if ((want_nack ? nack_v[s] : gnt_v[s]) === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      $display("FAIL %s: no pulse on slot %0d within %0d cycles", name, s, budget);
    end
  endtask

  initial begin
    int lat, ng, nn, seen;
    int order[$];
    int held[$];
    logic [NS-1:0] nacked;

    rst = 1'b1; req_v = '0; rel_v = '0; dst_v = '0;
    repeat (2) tick();
    check("rst_gnt", gnt_v, '0);
    check("rst_nack", nack_v, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_imcfg", imcfg, '0);
    check("rst_cfg", {scfg, ncfg, wcfg, ecfg, lcfg}, '0);
    rst = 1'b0;

    // L->S first path: CM0, latency 4
    request(8, 0);
    wait_pulse(8, 1'b0, 10, "t2_gnt", lat);
    check("t2_latency", 64'(lat), 64'd4);
    check("t2_gnt_cm", gnt_cm, 2'b01);
    check("t2_imcfg", imcfg, 20'h10000);
    check("t2_scfg", scfg, 4'h2);

    // Second L VC must go through CM1
    request(9, 0);
    wait_pulse(9, 1'b0, 10, "t3_gnt", lat);
    check("t3_gnt_cm", gnt_cm, 2'b10);
    check("t3_imcfg", imcfg, 20'h90000);
    check("t3_scfg", scfg, 4'hA);

    // N->S blocked until the first L path is released
    request(4, 0);
    seen = 0;
    repeat (20) begin
      tick();
      if (gnt_v[4]) seen++;
    end
    check("t3_blocked", 64'(seen), 64'd0);
    rel_v[8] = 1'b1;
    wait_pulse(4, 1'b0, 20, "t3_regnt", lat);
    check("t3_regnt_cm", gnt_cm, 2'b01);
    check("t3_regnt_scfg", scfg, 4'h9);
    check("t3_regnt_imcfg", imcfg, 20'h80100);

    // Illegal turns: W->S and S->S
    request(2, 0);
    wait_pulse(2, 1'b1, 10, "t4_nack_ws", lat);
    check("t4_nack_latency", 64'(lat), 64'd4);
    check("t4_nack_gnt", gnt_v, '0);
    check("t4_imcfg", imcfg, 20'h80100);
    request(0, 0);
    wait_pulse(0, 1'b1, 10, "t4_nack_uturn", lat);
    check("t4_scfg", scfg, 4'h9);
    rel_v[9] = 1'b1; rel_v[4] = 1'b1;
    tick(); tick();
    check("t4_cleared", imcfg, '0);

    // All slots toward L: grants in rr order, L->L rejected
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int s = 0; s < NS; s++) request(s, 4);
    ng = 0; nn = 0; nacked = '0;
    for (int c = 0; c < 600 && !(ng == 8 && nn == 2); c++) begin
      tick();
      for (int s = 0; s < NS; s++) begin
        if (gnt_v[s]) begin order.push_back(s); held.push_back(s); ng++; end
        if (nack_v[s]) begin nacked[s] = 1'b1; nn++; end
      end
      if (held.size() == MN) rel_v[held.pop_front()] = 1'b1;
    end
    check("t5_grants", 64'(ng), 64'd8);
    check("t5_nacked", nacked, 10'h300);
    foreach (order[i]) check("t5_order", 64'(order[i]), 64'(i));
    while (held.size() > 0) rel_v[held.pop_front()] = 1'b1;
    tick(); tick();

    // Reset during route evaluation with two live paths
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    request(0, 4);
    wait_pulse(0, 1'b0, 10, "t6_gnt0", lat);
    request(4, 0);
    wait_pulse(4, 1'b0, 10, "t6_gnt4", lat);
    check("t6_imcfg", imcfg, 20'h00101);
    check("t6_lcfg", lcfg, 8'h01);
    check("t6_scfg", scfg, 4'h1);
    request(6, 1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (phase == 2) begin seen = 1; break; end
    end
    check("t6_reached_search", 64'(seen), 64'd1);
    rst = 1'b1; req_v = '0;
    tick();
    check("t6_rst_imcfg", imcfg, '0);
    check("t6_rst_cfg", {scfg, ncfg, wcfg, ecfg, lcfg}, '0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_gnt", gnt_v, '0);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      tick();
      if (gnt_v != '0) seen++;
    end
    check("t6_no_late_gnt", 64'(seen), 64'd0);

    // Randomized traffic with releases, withdrawals and occasional reset
    repeat (3000) begin
      tick();
      rst = ($urandom_range(499) == 0);
      for (int s = 0; s < NS; s++) begin
        if (m_alloc[s] >= 0) begin
          if ($urandom_range(15) == 0) rel_v[s] = 1'b1;
        end else if (req_v[s]) begin
          if ($urandom_range(63) == 0) req_v[s] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          request(s, int'($urandom_range(4)));
        end else if ($urandom_range(31) == 0) begin
          rel_v[s] = 1'b1;
        end
      end
    end
    rst = 1'b0; req_v = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
